// File: rtl/rf8088_pkg.sv
// Shared bus-cycle types, arbiter states and inactive-bus constants for the rf8088 core.
package rf8088_pkg;

    typedef enum logic [2:0] {
        CT_PASSIVE = 3'd0,
        CT_CODE    = 3'd1,
        CT_RDMEM   = 3'd2,
        CT_WRMEM   = 3'd3,
        CT_RDIO    = 3'd4,
        CT_WRIO    = 3'd5,
        CT_INTA    = 3'd6
    } e_cyc_type;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CODE,
        ST_DATA,
        ST_DONE
    } e_arb_state;

    // Wide enough for the big-segment build; narrower buses take the low bits.
    localparam logic [23:0] ADDRESS_INACTIVE = 24'hFF_FFFF;
    localparam logic [7:0]  DATA_INACTIVE    = 8'hFF;

    function automatic e_cyc_type data_cyc_type(input logic we, input logic io);
        case ({io, we})
            2'b00:   return CT_RDMEM;
            2'b01:   return CT_WRMEM;
            2'b10:   return CT_RDIO;
            default: return CT_WRIO;
        endcase
    endfunction

endpackage

// File: rtl/rf8088_bus_arb.sv
// Two-port (code fetch / execution data) arbiter for the rf8088 8-bit external bus.
// Optional wait-state timeout with berr_o: define RF8088_BUS_TIMEOUT_EN.
module rf8088_bus_arb
    import rf8088_pkg::*;
#(
    parameter int         AMSB     = 19,
    parameter logic [7:0] DFLT_DAT = 8'hFF
) (
    input  logic          rst_i,
    input  logic          clk_i,

    input  logic          creq_i,
    input  logic [AMSB:0] cadr_i,
    input  logic          cflush_i,
    output logic          cack_o,
    output logic [7:0]    cdat_o,

    input  logic          dreq_i,
    input  logic          dwe_i,
    input  logic          dio_i,
    input  logic          dlock_i,
    input  logic [AMSB:0] dadr_i,
    input  logic [7:0]    ddat_i,
    output logic          dack_o,
    output logic [7:0]    ddat_o,

    output logic          cyc_o,
    output logic          stb_o,
    output logic          we_o,
    output logic          lock_o,
    output logic [2:0]    cyc_type_o,
    output logic [AMSB:0] adr_o,
    output logic [7:0]    dat_o,
    input  logic [7:0]    dat_i,
    input  logic          ack_i
`ifdef RF8088_BUS_TIMEOUT_EN
    ,
    output logic          berr_o
`endif
);

    localparam logic [AMSB:0] ADR_IDLE = ADDRESS_INACTIVE[AMSB:0];

    e_arb_state state;
    e_cyc_type  cyc_type;
    logic       cack_q;
    logic       flushed;
    logic       unlock;

    logic       idle_like;
    logic       in_cycle;
    logic       grant_d;
    logic       grant_c;
    logic       term;
    logic       timeout;
    logic [7:0] bus_dat;

    assign cyc_type_o = cyc_type;

    // Grant decisions are also taken in DONE so back-to-back cycles lose no extra clock.
    assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
    assign in_cycle  = (state == ST_CODE) || (state == ST_DATA);
    assign grant_d   = idle_like && dreq_i;
    assign grant_c   = idle_like && !dreq_i && creq_i && !cflush_i && !lock_o;

`ifdef RF8088_BUS_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       berr_q;

    assign timeout = in_cycle && !ack_i && (wait_cnt == 8'hFF);
    assign term    = (in_cycle && ack_i) || timeout;
    assign bus_dat = ack_i ? dat_i : DATA_INACTIVE;
    assign berr_o  = berr_q && (cack_o || dack_o);

    always_ff @(posedge clk_i) begin
        if (rst_i || grant_d || grant_c) begin
            wait_cnt <= 8'd0;
        end else if (in_cycle && wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
        berr_q <= !rst_i && timeout;
    end
`else
    assign timeout = 1'b0;
    assign term    = in_cycle && ack_i;
    assign bus_dat = dat_i;
`endif

    // A flush arriving in the DONE cycle still cancels the fetch as seen by the core.
    assign cack_o = cack_q && !cflush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            cyc_o    <= 1'b0;
            stb_o    <= 1'b0;
            we_o     <= 1'b0;
            lock_o   <= 1'b0;
            cyc_type <= CT_PASSIVE;
            adr_o    <= ADR_IDLE;
            dat_o    <= DFLT_DAT;
            cack_q   <= 1'b0;
            dack_o   <= 1'b0;
            cdat_o   <= DATA_INACTIVE;
            ddat_o   <= DATA_INACTIVE;
            flushed  <= 1'b0;
            unlock   <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults make the acks one-cycle pulses; a later
            // assignment in the same block overrides them for this edge only.
            cack_q <= 1'b0;
            dack_o <= 1'b0;

            case (state)
                ST_IDLE, ST_DONE: begin
                    state <= ST_IDLE;
                    if (grant_d) begin
                        state    <= ST_DATA;
                        cyc_o    <= 1'b1;
                        stb_o    <= 1'b1;
                        we_o     <= dwe_i;
                        adr_o    <= dadr_i;
                        dat_o    <= dwe_i ? ddat_i : DFLT_DAT;
                        cyc_type <= data_cyc_type(dwe_i, dio_i);
                        unlock   <= !dlock_i;
                        if (dlock_i) begin
                            lock_o <= 1'b1;
                        end
                    end else if (grant_c) begin
                        state    <= ST_CODE;
                        cyc_o    <= 1'b1;
                        stb_o    <= 1'b1;
                        we_o     <= 1'b0;
                        adr_o    <= cadr_i;
                        dat_o    <= DFLT_DAT;
                        cyc_type <= CT_CODE;
                        flushed  <= 1'b0;
                    end
                end

                ST_CODE, ST_DATA: begin
                    if (state == ST_CODE && cflush_i) begin
                        flushed <= 1'b1;
                    end
                    if (term) begin
                        state    <= ST_DONE;
                        cyc_o    <= 1'b0;
                        stb_o    <= 1'b0;
                        we_o     <= 1'b0;
                        cyc_type <= CT_PASSIVE;
                        adr_o    <= ADR_IDLE;
                        dat_o    <= DFLT_DAT;
                        if (state == ST_CODE) begin
                            // A flushed fetch finishes on the bus but its byte is discarded.
                            if (!(flushed || cflush_i)) begin
                                cdat_o <= bus_dat;
                                cack_q <= 1'b1;
                            end
                        end else begin
                            ddat_o <= bus_dat;
                            dack_o <= 1'b1;
                            if (unlock) begin
                                lock_o <= 1'b0;
                            end
                        end
                        if (timeout) begin
                            lock_o <= 1'b0;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf8088_bus_arb.sv
// Self-checking bench for rf8088_bus_arb (default build, timeout feature disabled).
module tb_rf8088_bus_arb;
    import rf8088_pkg::*;

    localparam int AMSB = 19;

    logic            rst_i = 1'b1;
    logic            clk_i = 1'b0;
    logic            creq_i = 1'b0, cflush_i = 1'b0;
    logic [AMSB:0]   cadr_i = '0;
    logic            cack_o;
    logic [7:0]      cdat_o;
    logic            dreq_i = 1'b0, dwe_i = 1'b0, dio_i = 1'b0, dlock_i = 1'b0;
    logic [AMSB:0]   dadr_i = '0;
    logic [7:0]      ddat_i = '0;
    logic            dack_o;
    logic [7:0]      ddat_o;
    logic            cyc_o, stb_o, we_o, lock_o;
    logic [2:0]      cyc_type_o;
    logic [AMSB:0]   adr_o;
    logic [7:0]      dat_o;
    logic [7:0]      dat_i = '0;
    logic            ack_i = 1'b0;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_cdat = 8'hFF;
    logic [7:0] exp_ddat = 8'hFF;

    rf8088_bus_arb #(.AMSB(AMSB), .DFLT_DAT(8'hFF)) dut (
        .rst_i(rst_i), .clk_i(clk_i),
        .creq_i(creq_i), .cadr_i(cadr_i), .cflush_i(cflush_i), .cack_o(cack_o), .cdat_o(cdat_o),
        .dreq_i(dreq_i), .dwe_i(dwe_i), .dio_i(dio_i), .dlock_i(dlock_i), .dadr_i(dadr_i),
        .ddat_i(ddat_i), .dack_o(dack_o), .ddat_o(ddat_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .lock_o(lock_o), .cyc_type_o(cyc_type_o),
        .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i)
    );

    always #5 clk_i = ~clk_i;

    // Advance to just after the next rising edge(s); inputs change and outputs are sampled here.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic quiet();
        creq_i = 1'b0; cflush_i = 1'b0; dreq_i = 1'b0; dwe_i = 1'b0;
        dio_i = 1'b0; dlock_i = 1'b0; ack_i = 1'b0;
    endtask

    // Bus cycle type from the requester's write/IO flags, by the encoding order of e_cyc_type.
    function automatic logic [2:0] model_ct(input logic we, input logic io);
        return 3'(2 + int'(we) + 2 * int'(io));
    endfunction

    task automatic test_reset();
        rst_i = 1'b1;
        quiet();
        step(3);
        total++;
        if ({cyc_o, stb_o, we_o, lock_o, cack_o, dack_o} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 000000", {cyc_o, stb_o, we_o, lock_o, cack_o, dack_o});
        end
        total++;
        if ({cyc_type_o, adr_o, dat_o} !== {CT_PASSIVE, 20'hFFFFF, 8'hFF}) begin
            bad++; $display("FAIL reset_bus: got ct=%0d adr=%h dat=%h", cyc_type_o, adr_o, dat_o);
        end
        total++;
        if ({cdat_o, ddat_o} !== 16'hFFFF) begin
            bad++; $display("FAIL reset_rdata: got cdat=%h ddat=%h want FF FF", cdat_o, ddat_o);
        end
        rst_i = 1'b0;
        step();
        total++;
        if ({cyc_o, stb_o} !== 2'b00) begin
            bad++; $display("FAIL reset_release: got cyc/stb=%b want 00", {cyc_o, stb_o});
        end
        exp_cdat = 8'hFF;
        exp_ddat = 8'hFF;
    endtask

    task automatic test_code_fetch();
        creq_i = 1'b1; cadr_i = 20'hFFFF0;
        step();
        total++;
        if ({cyc_o, stb_o, we_o, cyc_type_o, adr_o} !== {3'b110, CT_CODE, 20'hFFFF0}) begin
            bad++; $display("FAIL code_start: got ctl=%b ct=%0d adr=%h", {cyc_o, stb_o, we_o}, cyc_type_o, adr_o);
        end
        step(2);
        ack_i = 1'b1; dat_i = 8'hEA; creq_i = 1'b0;
        total++;
        if (cack_o !== 1'b0) begin
            bad++; $display("FAIL code_early_ack: got cack=%b want 0", cack_o);
        end
        step();
        ack_i = 1'b0;
        exp_cdat = 8'hEA;
        total++;
        if ({cack_o, cdat_o, cyc_o, stb_o, cyc_type_o} !== {1'b1, exp_cdat, 2'b00, CT_PASSIVE}) begin
            bad++; $display("FAIL code_done: got cack=%b cdat=%h cyc/stb=%b ct=%0d want 1 %h 00 0",
                            cack_o, cdat_o, {cyc_o, stb_o}, cyc_type_o, exp_cdat);
        end
        step();
        total++;
        if (cack_o !== 1'b0) begin
            bad++; $display("FAIL code_pulse: got cack=%b want 0", cack_o);
        end
    endtask

    task automatic test_simultaneous();
        logic [AMSB:0] ca;
        logic [7:0]    rd, cd;
        ca = AMSB'($urandom);
        rd = 8'($urandom);
        cd = 8'($urandom);
        creq_i = 1'b1; cadr_i = ca;
        dreq_i = 1'b1; dwe_i = 1'b1; dio_i = 1'b0; dadr_i = 20'h00400; ddat_i = 8'h55;
        step();
        total++;
        if ({cyc_o, stb_o, we_o, cyc_type_o, adr_o, dat_o} !== {3'b111, CT_WRMEM, 20'h00400, 8'h55}) begin
            bad++; $display("FAIL simul_data_first: got ctl=%b ct=%0d adr=%h dat=%h",
                            {cyc_o, stb_o, we_o}, cyc_type_o, adr_o, dat_o);
        end
        step();
        ack_i = 1'b1; dat_i = rd; dreq_i = 1'b0;
        step();
        ack_i = 1'b0;
        exp_ddat = rd;
        total++;
        if ({dack_o, ddat_o, stb_o, cack_o} !== {1'b1, exp_ddat, 1'b0, 1'b0}) begin
            bad++; $display("FAIL simul_dack: got dack=%b ddat=%h stb=%b cack=%b want 1 %h 0 0",
                            dack_o, ddat_o, stb_o, cack_o, exp_ddat);
        end
        step();
        total++;
        if ({stb_o, we_o, cyc_type_o, adr_o, dat_o} !== {2'b10, CT_CODE, ca, 8'hFF}) begin
            bad++; $display("FAIL simul_code_next: got stb/we=%b ct=%0d adr=%h dat=%h want 10 1 %h FF",
                            {stb_o, we_o}, cyc_type_o, adr_o, dat_o, ca);
        end
        ack_i = 1'b1; dat_i = cd; creq_i = 1'b0;
        step();
        ack_i = 1'b0;
        exp_cdat = cd;
        total++;
        if ({cack_o, cdat_o} !== {1'b1, exp_cdat}) begin
            bad++; $display("FAIL simul_cack: got cack=%b cdat=%h want 1 %h", cack_o, cdat_o, exp_cdat);
        end
        step();
    endtask

    task automatic test_lock();
        logic [AMSB:0] ca;
        logic [7:0]    d1, d2;
        ca = AMSB'($urandom);
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        creq_i = 1'b1; cadr_i = ca;
        dreq_i = 1'b1; dlock_i = 1'b1; dwe_i = 1'b0; dio_i = 1'b1; dadr_i = 20'h00060;
        step();
        total++;
        if ({stb_o, lock_o, cyc_type_o, adr_o} !== {2'b11, CT_RDIO, 20'h00060}) begin
            bad++; $display("FAIL lock_first: got stb/lock=%b ct=%0d adr=%h", {stb_o, lock_o}, cyc_type_o, adr_o);
        end
        ack_i = 1'b1; dat_i = d1; dreq_i = 1'b0; dlock_i = 1'b0;
        step();
        ack_i = 1'b0;
        exp_ddat = d1;
        total++;
        if ({dack_o, ddat_o, lock_o} !== {1'b1, exp_ddat, 1'b1}) begin
            bad++; $display("FAIL lock_held_done: got dack=%b ddat=%h lock=%b want 1 %h 1", dack_o, ddat_o, lock_o, exp_ddat);
        end
        step();
        total++;
        if ({cyc_o, lock_o} !== 2'b01) begin
            bad++; $display("FAIL lock_code_stall: got cyc/lock=%b want 01", {cyc_o, lock_o});
        end
        dreq_i = 1'b1; dlock_i = 1'b0; dwe_i = 1'b1; dio_i = 1'b0; dadr_i = 20'h00061; ddat_i = d2;
        step();
        total++;
        if ({stb_o, lock_o, cyc_type_o, dat_o} !== {2'b11, CT_WRMEM, d2}) begin
            bad++; $display("FAIL lock_second: got stb/lock=%b ct=%0d dat=%h", {stb_o, lock_o}, cyc_type_o, dat_o);
        end
        step();
        ack_i = 1'b1; dat_i = 8'h00; dreq_i = 1'b0;
        total++;
        if (lock_o !== 1'b1) begin
            bad++; $display("FAIL lock_until_ack: got lock=%b want 1", lock_o);
        end
        step();
        ack_i = 1'b0;
        exp_ddat = 8'h00;
        total++;
        if ({dack_o, lock_o, cyc_o} !== 3'b100) begin
            bad++; $display("FAIL lock_release: got dack/lock/cyc=%b want 100", {dack_o, lock_o, cyc_o});
        end
        step();
        total++;
        if ({stb_o, lock_o, cyc_type_o, adr_o} !== {2'b10, CT_CODE, ca}) begin
            bad++; $display("FAIL lock_code_grant: got stb/lock=%b ct=%0d adr=%h want 10 1 %h",
                            {stb_o, lock_o}, cyc_type_o, adr_o, ca);
        end
        ack_i = 1'b1; dat_i = d1 ^ 8'h5A; creq_i = 1'b0;
        step();
        ack_i = 1'b0;
        exp_cdat = d1 ^ 8'h5A;
        total++;
        if ({cack_o, cdat_o} !== {1'b1, exp_cdat}) begin
            bad++; $display("FAIL lock_code_cack: got cack=%b cdat=%h want 1 %h", cack_o, cdat_o, exp_cdat);
        end
        step();
    endtask

    task automatic test_flush();
        logic [7:0] fd;
        fd = exp_cdat ^ 8'hC3;
        creq_i = 1'b1; cadr_i = 20'h12345;
        step();
        cflush_i = 1'b1; creq_i = 1'b0;
        step();
        cflush_i = 1'b0;
        total++;
        if ({cyc_o, stb_o, cyc_type_o} !== {2'b11, CT_CODE}) begin
            bad++; $display("FAIL flush_no_abort: got cyc/stb=%b ct=%0d want 11 1", {cyc_o, stb_o}, cyc_type_o);
        end
        step();
        ack_i = 1'b1; dat_i = fd;
        step();
        ack_i = 1'b0;
        total++;
        if ({cack_o, cdat_o, stb_o} !== {1'b0, exp_cdat, 1'b0}) begin
            bad++; $display("FAIL flush_suppress: got cack=%b cdat=%h stb=%b want 0 %h 0", cack_o, cdat_o, stb_o, exp_cdat);
        end
        step();
        // Flush arriving in the DONE cycle.
        creq_i = 1'b1; cadr_i = 20'h0ABCD;
        step();
        ack_i = 1'b1; dat_i = fd; creq_i = 1'b0;
        step();
        ack_i = 1'b0; cflush_i = 1'b1;
        exp_cdat = fd;
        #1;
        total++;
        if (cack_o !== 1'b0) begin
            bad++; $display("FAIL flush_in_done: got cack=%b want 0", cack_o);
        end
        step();
        cflush_i = 1'b0;
        total++;
        if ({cack_o, cyc_o, cdat_o} !== {2'b00, exp_cdat}) begin
            bad++; $display("FAIL flush_done_after: got cack/cyc=%b cdat=%h want 00 %h", {cack_o, cyc_o}, cdat_o, exp_cdat);
        end
    endtask

    task automatic test_stray_ack();
        ack_i = 1'b1; dat_i = 8'h99;
        step(2);
        total++;
        if ({cack_o, dack_o, cyc_o, cdat_o, ddat_o} !== {3'b000, exp_cdat, exp_ddat}) begin
            bad++; $display("FAIL stray_ack: got cack/dack/cyc=%b cdat=%h ddat=%h", {cack_o, dack_o, cyc_o}, cdat_o, ddat_o);
        end
        ack_i = 1'b0;
        step();
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            logic          do_d, do_c, we, io, flush;
            logic [AMSB:0] da, ca;
            logic [7:0]    wd, rd, cd;
            int            lat_d, lat_c, sel;
            sel   = $urandom_range(0, 2);
            do_d  = (sel != 1);
            do_c  = (sel != 0);
            we    = 1'($urandom); io = 1'($urandom);
            flush = ($urandom_range(0, 3) == 0);
            da = AMSB'($urandom); ca = AMSB'($urandom);
            wd = 8'($urandom); rd = 8'($urandom); cd = 8'($urandom);
            lat_d = $urandom_range(0, 3); lat_c = $urandom_range(0, 3);

            creq_i = do_c; cadr_i = ca;
            dreq_i = do_d; dwe_i = we; dio_i = io; dadr_i = da; ddat_i = wd; dlock_i = 1'b0;
            step();
            if (do_d) begin
                total++;
                if ({stb_o, we_o, cyc_type_o, adr_o, dat_o} !== {1'b1, we, model_ct(we, io), da, (we ? wd : 8'hFF)}) begin
                    bad++; $display("FAIL rnd_data_start it=%0d: got stb/we=%b ct=%0d adr=%h dat=%h want 1%b %0d %h",
                                    it, {stb_o, we_o}, cyc_type_o, adr_o, dat_o, we, model_ct(we, io), da);
                end
                step(lat_d);
                ack_i = 1'b1; dat_i = rd; dreq_i = 1'b0;
                step();
                ack_i = 1'b0;
                exp_ddat = rd;
                total++;
                if ({dack_o, ddat_o, lock_o} !== {1'b1, exp_ddat, 1'b0}) begin
                    bad++; $display("FAIL rnd_dack it=%0d: got dack=%b ddat=%h lock=%b want 1 %h 0",
                                    it, dack_o, ddat_o, lock_o, exp_ddat);
                end
                step();
            end
            if (do_c) begin
                total++;
                if ({stb_o, we_o, cyc_type_o, adr_o} !== {2'b10, CT_CODE, ca}) begin
                    bad++; $display("FAIL rnd_code_start it=%0d: got stb/we=%b ct=%0d adr=%h want 10 1 %h",
                                    it, {stb_o, we_o}, cyc_type_o, adr_o, ca);
                end
                cflush_i = flush;
                for (int k = 0; k < lat_c; k++) begin
                    step();
                    cflush_i = 1'b0;
                end
                ack_i = 1'b1; dat_i = cd; creq_i = 1'b0;
                step();
                ack_i = 1'b0; cflush_i = 1'b0;
                if (!flush) exp_cdat = cd;
                total++;
                if ({cack_o, cdat_o} !== {!flush, exp_cdat}) begin
                    bad++; $display("FAIL rnd_cack it=%0d: got cack=%b cdat=%h want %b %h",
                                    it, cack_o, cdat_o, !flush, exp_cdat);
                end
                step();
            end
            total++;
            if ({cyc_o, stb_o, cack_o, dack_o} !== 4'b0000) begin
                bad++; $display("FAIL rnd_idle it=%0d: got cyc/stb/cack/dack=%b want 0000",
                                it, {cyc_o, stb_o, cack_o, dack_o});
            end
        end
    endtask

    task automatic test_reset_mid_cycle();
        creq_i = 1'b1; cadr_i = 20'h54321;
        step();
        total++;
        if (stb_o !== 1'b1) begin
            bad++; $display("FAIL rstmid_start: got stb=%b want 1", stb_o);
        end
        rst_i = 1'b1; ack_i = 1'b1; dat_i = 8'h77; creq_i = 1'b0;
        step();
        rst_i = 1'b0; ack_i = 1'b0;
        exp_cdat = 8'hFF;
        exp_ddat = 8'hFF;
        total++;
        if ({cyc_o, stb_o, cack_o, dack_o, cyc_type_o, adr_o} !== {4'b0000, CT_PASSIVE, 20'hFFFFF}) begin
            bad++; $display("FAIL rstmid_drop: got cyc/stb/cack/dack=%b ct=%0d adr=%h want 0000 0 FFFFF",
                            {cyc_o, stb_o, cack_o, dack_o}, cyc_type_o, adr_o);
        end
        step();
        total++;
        if ({cyc_o, cack_o, dack_o, cdat_o} !== {3'b000, exp_cdat}) begin
            bad++; $display("FAIL rstmid_no_ack: got cyc/cack/dack=%b cdat=%h want 000 %h",
                            {cyc_o, cack_o, dack_o}, cdat_o, exp_cdat);
        end
    endtask

    initial begin
        test_reset();
        test_code_fetch();
        test_simultaneous();
        test_lock();
        test_flush();
        test_stray_ack();
        test_random();
        test_reset_mid_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
